uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_sampler.sv | 45 ++++
 rtl/uart_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: 3-bit FSM state encodings and the per-frame configuration record.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  typedef struct packed {
    logic [15:0] div;
    logic [4:0]  bpw;
    logic        par_en;
    logic        odd;
    logic        two_stop;
  } uart_cfg_t;

endpackage

// File: rtl/uart_baud_sampler.sv
// Receive front end: 2-flop synchronizer, falling-edge detect and bit-period sample counter.
module uart_baud_sampler (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic [15:0] div_i,
  input  logic        start_i,
  input  logic        en_i,
  output logic        rx_o,
  output logic        fall_o,
  output logic        sample_o,
  output logic        boundary_o
);

  logic        s1_q, s2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = 16'd1;
    else if (en_i)
      cnt_d = (cnt_q == div_i) ? 16'd1 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      cnt_q  <= cnt_d;
    end
  end

  assign rx_o       = s2_q;
  assign fall_o     = prev_q & ~s2_q;
  assign sample_o   = en_i && (cnt_q == (div_i >> 1));
  assign boundary_o = en_i && (cnt_q == div_i);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: framing FSM and datapath with runtime-configured word size, parity and stop bits.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] clk_div,
  input  logic [4:0]  bits_per_word,
  input  logic        parity_en,
  input  logic        parity_evan_odd,
  input  logic        two_stop_bit,
  input  logic        rd_en,
  output logic [15:0] data_out,
  output logic        data_ready,
  output logic        busy,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun
);

  logic [2:0]  state_q, state_d;
  uart_cfg_t   cfg_q, cfg_d;
  logic [4:0]  bitpos_q, bitpos_d;
  logic [15:0] shift_q, shift_d;
  logic        par_q, par_d, ferr_q, ferr_d;
  logic [15:0] data_q, data_d;
  logic        ready_q, ready_d, perr_q, perr_d, fout_q, fout_d, ovr_q, ovr_d;
  logic        rx_s, fall, sample, boundary, start, done;

  assign start = (state_q == ST_IDLE) && fall;

  uart_baud_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .div_i      (cfg_q.div),
    .start_i    (start),
    .en_i       (state_q != ST_IDLE),
    .rx_o       (rx_s),
    .fall_o     (fall),
    .sample_o   (sample),
    .boundary_o (boundary)
  );

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    bitpos_d = bitpos_q;
    shift_d  = shift_q;
    par_d    = par_q;
    ferr_d   = ferr_q;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: if (fall) begin
        state_d  = ST_START;
        cfg_d    = '{div: clk_div, bpw: bits_per_word, par_en: parity_en,
                     odd: parity_evan_odd, two_stop: two_stop_bit};
        bitpos_d = '0;
        shift_d  = '0;
        par_d    = 1'b0;
        ferr_d   = 1'b0;
      end
      ST_START: begin
        if (sample && rx_s) state_d = ST_IDLE;
        else if (boundary)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sample) begin
          shift_d[bitpos_q[3:0]] = rx_s;
          par_d = par_q ^ rx_s;
        end
        if (boundary) begin
          if (bitpos_q == cfg_q.bpw) state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
          else                       bitpos_d = bitpos_q + 5'd1;
        end
      end
      ST_PARITY: begin
        if (sample)   par_d = par_q ^ rx_s;
        if (boundary) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample) begin
          if (!rx_s) ferr_d = 1'b1;
          if (!cfg_q.two_stop) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (boundary) state_d = ST_STOP2;
      end
      ST_STOP2: if (sample) begin
        if (!rx_s) ferr_d = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completing word beats a simultaneous acknowledge: ready stays set, overrun does not.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    perr_d  = perr_q;
    fout_d  = fout_q;
    ovr_d   = ovr_q;
    if (done) begin
      data_d  = shift_q;
      ready_d = 1'b1;
      perr_d  = cfg_q.par_en & (par_q ^ cfg_q.odd);
      fout_d  = ferr_q | ~rx_s;
      ovr_d   = rd_en ? 1'b0 : (ovr_q | ready_q);
    end else if (rd_en) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      bitpos_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      perr_q   <= 1'b0;
      fout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      perr_q   <= perr_d;
      fout_q   <= fout_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_ready = ready_q;
  assign busy       = (state_q != ST_IDLE);
  assign parity_err = perr_q;
  assign frame_err  = fout_q;
  assign overrun    = ovr_q;

endmodule
